booth_pp_accum: RTL and testbench

Sequential consumer for the radix-4 Booth partial-product stream produced by the team's Booth encoder. It accepts one M-bit two's-complement partial product per handshake, in order from group 0 (LSB) upward. Each one is shifted left by 2*index and added into an M-bit accumulator. After NPP products it presents the final product to the downstream mantissa-normalisation stage.

---
 rtl/booth_pp_accum.sv | 100 ++++++++++
 tb/tb_booth_pp_accum.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accum.sv
// rtl/booth_pp_accum.sv - radix-4 Booth partial-product shift-and-accumulate stage
// Consumes NPP two's-complement partial products (LSB group first) and presents their weighted sum.
module booth_pp_accum #(
  parameter int N   = 32,
  parameter int M   = 2 * N,
  parameter int NPP = N / 2 + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [M-1:0] i_pp_in,
  input  logic         i_pp_valid,
  output logic         o_pp_ready,
  output logic [M-1:0] o_prod,
  output logic         o_prod_valid,
  input  logic         i_prod_ready,
  output logic         o_busy
);

  localparam int IW = (NPP > 1) ? $clog2(NPP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NPP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [M-1:0]   r_acc;
  logic [M-1:0]   w_acc_nxt;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_idx_nxt;
  logic [IW:0]    w_shamt;
  logic [M-1:0]   w_pp_shifted;

  // Group weight is 4^idx; bits pushed past M-1 are dropped, giving mod-2^M arithmetic.
  assign w_shamt      = {r_idx, 1'b0};
  assign w_pp_shifted = i_pp_in << w_shamt;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_acc_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (i_pp_valid) begin
          w_acc_nxt = r_acc + w_pp_shifted;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_DONE: begin
        // A start coincident with the product handshake chains straight into the next operation.
        if (i_prod_ready) begin
          if (i_start) begin
            w_acc_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_ACCUM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign o_pp_ready   = (r_state == S_ACCUM);
  assign o_prod_valid = (r_state == S_DONE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_prod       = r_acc;

endmodule

// File: tb/tb_booth_pp_accum.sv
// tb/tb_booth_pp_accum.sv - randomized self-checking bench for booth_pp_accum
// Reference: Booth digits from multiplier bits, expected sums by plain integer arithmetic.
module tb_booth_pp_accum;

  localparam int N   = 32;
  localparam int M   = 64;
  localparam int NPP = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [M-1:0] pp_in = '0;
  logic         pp_valid = 1'b0;
  logic         pp_ready;
  logic [M-1:0] prod;
  logic         prod_valid;
  logic         prod_ready = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  booth_pp_accum #(.N(N), .M(M), .NPP(NPP)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_pp_in      (pp_in),
    .i_pp_valid   (pp_valid),
    .o_pp_ready   (pp_ready),
    .o_prod       (prod),
    .o_prod_valid (prod_valid),
    .i_prod_ready (prod_ready),
    .o_busy       (busy)
  );

  int errors = 0;
  int checks = 0;
  logic [M-1:0] pps [NPP];

  task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] ref_sum();
    logic [M-1:0] s = '0;
    for (int i = 0; i < NPP; i++) s = s + (pps[i] << (2 * i));
    return s;
  endfunction

  function automatic void load_simple(input logic [M-1:0] a, input logic [M-1:0] b);
    for (int i = 0; i < NPP; i++) pps[i] = '0;
    pps[0] = a;
    pps[1] = b;
  endfunction

  // Unsigned multiplier: bit k of ye is y[k-1], ye[0] is the implicit y[-1]=0, top bits zero.
  function automatic void load_booth(input logic [31:0] m, input logic [31:0] y);
    logic [35:0] ye;
    int d;
    ye = {3'b000, y, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      d = int'(ye[2*i]) + int'(ye[2*i+1]) - 2 * int'(ye[2*i+2]);
      pps[i] = 64'(longint'(d) * longint'({32'd0, m}));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pp_ready_after_start", {63'd0, pp_ready}, 64'd1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic send_pps(input bit gaps, input int n_send, input int start_pulse_at);
    bit v;
    for (int i = 0; i < n_send; i++) begin
      do begin
        v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        pp_valid = v;
        pp_in    = v ? pps[i] : {$urandom, $urandom};
        if (i == start_pulse_at) start = 1'b1;
        tick();
        start = 1'b0;
      end while (!v);
    end
    pp_valid = 1'b0;
  endtask

  task automatic finish_result(input string tag, input logic [M-1:0] exp);
    check("prod_valid_done", {63'd0, prod_valid}, 64'd1);
    check("busy_done", {63'd0, busy}, 64'd1);
    check("pp_ready_done", {63'd0, pp_ready}, 64'd0);
    check(tag, prod, exp);
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    check("prod_valid_after_hs", {63'd0, prod_valid}, 64'd0);
    check("busy_after_hs", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int cnt;
    int k;
    logic [31:0] m;
    logic [31:0] y;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pp_ready", {63'd0, pp_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_prod_valid", {63'd0, prod_valid}, 64'd0);
    check("rst_prod", prod, 64'd0);

    // Idle ignores pp_valid.
    pp_valid = 1'b1;
    pp_in = 64'd99;
    tick();
    pp_valid = 1'b0;
    check("idle_ignores_pp", {63'd0, busy}, 64'd0);

    // Scenario 1 with latency measurement.
    load_simple(64'd3, 64'd3);
    prod_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 1;
    k = 0;
    pp_valid = 1'b1;
    while (!prod_valid && cnt < 40) begin
      pp_in = (k < NPP) ? pps[k] : 64'd0;
      tick();
      cnt++;
      k++;
    end
    pp_valid = 1'b0;
    check("s1_latency", 64'(cnt), 64'(NPP + 1));
    check("s1_prod", prod, 64'd15);
    tick();
    prod_ready = 1'b0;
    check("s1_pv_one_cycle", {63'd0, prod_valid}, 64'd0);
    check("s1_busy_drop", {63'd0, busy}, 64'd0);

    // Scenario 2: negative partial product.
    load_simple(64'hFFFF_FFFF_FFFF_FFF2, 64'd7);
    do_start();
    send_pps(1'b0, NPP, -1);
    finish_result("s2_prod", 64'd14);

    // Max operands through the Booth reference.
    load_booth(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_start();
    send_pps(1'b0, NPP, -1);
    finish_result("max_prod", 64'hFFFF_FFFE_0000_0001);

    // Random operand pairs against a plain product.
    for (int t = 0; t < 200; t++) begin
      m = $urandom;
      y = $urandom;
      load_booth(m, y);
      do_start();
      send_pps(bit'($urandom_range(0, 1)), NPP, -1);
      finish_result("rand_prod", {32'd0, m} * {32'd0, y});
    end

    // Random raw partial products against the weighted-sum reference.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NPP; i++) pps[i] = {$urandom, $urandom};
      do_start();
      send_pps(1'b1, NPP, -1);
      finish_result("raw_sum", ref_sum());
    end

    // Backpressure: input gaps, then a stalled DONE with noise on other inputs.
    load_simple(64'd3, 64'd3);
    do_start();
    send_pps(1'b1, NPP, -1);
    for (int c = 0; c < 5; c++) begin
      pp_valid = bit'($urandom_range(0, 1));
      start    = bit'($urandom_range(0, 1));
      pp_in    = {$urandom, $urandom};
      tick();
      check("stall_prod_valid", {63'd0, prod_valid}, 64'd1);
      check("stall_prod", prod, 64'd15);
      check("stall_pp_ready", {63'd0, pp_ready}, 64'd0);
    end
    start = 1'b0;
    pp_valid = 1'b0;
    finish_result("gap_prod", 64'd15);

    // Reset after 8 accepts discards the partial result.
    load_simple(64'hFFFF_FFFF_FFFF_FFF2, 64'd7);
    for (int i = 2; i < NPP; i++) pps[i] = 64'd5;
    do_start();
    send_pps(1'b0, 8, -1);
    rst = 1'b1;
    pp_valid = 1'b1;
    tick();
    rst = 1'b0;
    pp_valid = 1'b0;
    check("midrst_pp_ready", {63'd0, pp_ready}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_prod_valid", {63'd0, prod_valid}, 64'd0);
    check("midrst_prod", prod, 64'd0);
    load_simple(64'hFFFF_FFFF_FFFF_FFF2, 64'd7);
    do_start();
    send_pps(1'b0, NPP, -1);
    finish_result("after_rst_prod", 64'd14);

    // Back-to-back with a stray start during ACCUM.
    load_simple(64'd3, 64'd3);
    do_start();
    send_pps(1'b0, NPP, 5);
    check("b2b_first_prod", prod, 64'd15);
    check("b2b_first_pv", {63'd0, prod_valid}, 64'd1);
    m = $urandom;
    y = $urandom;
    load_booth(m, y);
    prod_ready = 1'b1;
    start = 1'b1;
    tick();
    prod_ready = 1'b0;
    start = 1'b0;
    check("b2b_pp_ready", {63'd0, pp_ready}, 64'd1);
    check("b2b_pv_low", {63'd0, prod_valid}, 64'd0);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    send_pps(1'b0, NPP, -1);
    finish_result("b2b_second_prod", {32'd0, m} * {32'd0, y});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
